// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline stage sitting directly after the ID/EX latch. It registers
// the execute-stage result, owns the data-cache request for loads and stores,
// and presents a completed, writeback-ready entry to the MEM/WB latch.
//
// While a memory access is outstanding the request lines are held until
// dhit, and mem_stall freezes IF/ID, ID/EX and this stage's own input.
// stall_cycles counts (saturating) the REQ cycles that ended without dhit.
//
// Ports
//   CLK, RST           clock (rising edge) and synchronous active-high reset
//   pipe_en            global pipeline advance
//   ex_*               ID/EX entry: valid, dREN, dWEN, regWrite, MemtoReg,
//                      HALT, wsel, aluResult, storeData
//   dhit, dmemload     data-cache completion and load data
//   dmemREN/WEN        data-cache read / write request
//   dmemaddr/store     word-aligned address and store data (0 outside REQ)
//   mem_stall          upstream freeze, decoded from state only
//   mem_valid          entry complete and valid for MEM/WB
//   mem_regWrite       qualified register write (never to register 0)
//   mem_wsel/mem_wdat  destination register and writeback data
//   mem_HALT           sticky: a HALT has reached this stage
//   stall_cycles       saturating count of memory wait cycles
// ---------------------------------------------------------------------------
module ex_mem_stage #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pipe_en,
    input  logic              ex_valid,
    input  logic              ex_dREN,
    input  logic              ex_dWEN,
    input  logic              ex_regWrite,
    input  logic              ex_MemtoReg,
    input  logic              ex_HALT,
    input  logic [REG_AW-1:0] ex_wsel,
    input  logic [WORD_W-1:0] ex_aluResult,
    input  logic [WORD_W-1:0] ex_storeData,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_stall,
    output logic              mem_valid,
    output logic              mem_regWrite,
    output logic [REG_AW-1:0] mem_wsel,
    output logic [WORD_W-1:0] mem_wdat,
    output logic              mem_HALT,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;

    // Registered entry
    logic                ent_valid;
    logic                ent_regwrite;
    logic                ent_memtoreg;
    logic [REG_AW-1:0]   ent_wsel;
    logic [WORD_W-1:0]   ent_alu;
    logic [WORD_W-1:0]   ent_sdat;
    logic [WORD_W-1:0]   ldat;

    // Registered FSM outputs; all three are only ever set while in REQ
    logic                ren_q;
    logic                wen_q;
    logic                stall_q;

    logic                halt_seen;
    logic [CNT_W-1:0]    stall_cnt;

    logic                load_en;
    logic                take;
    logic                is_store;
    logic                is_load;

    // The stage input is frozen by its own stall, so a pending access can
    // never be overwritten by the upstream entry.
    assign load_en  = pipe_en & ~stall_q;

    // After a HALT has been seen every new entry is forced to a bubble.
    assign take     = ex_valid & ~halt_seen;

    // A simultaneous read and write request is treated as a store.
    assign is_store = ex_dWEN;
    assign is_load  = ex_dREN & ~ex_dWEN;

    // NOTE: reset is sampled synchronously inside the clocked block, and every
    // register here is updated with non-blocking assignments so all flops see
    // the same pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            ent_valid    <= 1'b0;
            ent_regwrite <= 1'b0;
            ent_memtoreg <= 1'b0;
            ent_wsel     <= '0;
            ent_alu      <= '0;
            ent_sdat     <= '0;
            ldat         <= '0;
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            stall_q      <= 1'b0;
            halt_seen    <= 1'b0;
            stall_cnt    <= '0;
        end else if (load_en) begin
            // New entry (real instruction or bubble) enters the stage.
            ent_valid    <= take;
            ent_regwrite <= take & ex_regWrite;
            // Store data path never writes back memory data; a dREN&dWEN
            // entry keeps its ALU result as writeback data.
            ent_memtoreg <= take & ex_MemtoReg & ~is_store;
            ent_wsel     <= take ? ex_wsel      : '0;
            ent_alu      <= take ? ex_aluResult : '0;
            ent_sdat     <= take ? ex_storeData : '0;

            if (take && ex_HALT) begin
                halt_seen <= 1'b1;
            end

            if (take && (is_load || is_store)) begin
                state   <= REQ;
                ren_q   <= is_load;
                wen_q   <= is_store;
                stall_q <= 1'b1;
            end else begin
                state   <= IDLE;
                ren_q   <= 1'b0;
                wen_q   <= 1'b0;
                stall_q <= 1'b0;
            end
        end else if (state == REQ) begin
            if (dhit) begin
                if (ren_q) begin
                    ldat <= dmemload;
                end
                // Requests drop here and are not re-issued from DONE.
                state   <= DONE;
                ren_q   <= 1'b0;
                wen_q   <= 1'b0;
                stall_q <= 1'b0;
            end else if (stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Cache interface: address and data are masked to zero outside REQ.
    assign dmemREN      = ren_q;
    assign dmemWEN      = wen_q;
    assign dmemaddr     = stall_q ? {ent_alu[WORD_W-1:2], 2'b00} : '0;
    assign dmemstore    = stall_q ? ent_sdat : '0;

    // Pipeline-facing outputs
    assign mem_stall    = stall_q;
    assign mem_valid    = ent_valid & ~stall_q;
    assign mem_regWrite = mem_valid & ent_regwrite & (ent_wsel != '0);
    assign mem_wsel     = ent_wsel;
    assign mem_wdat     = ent_memtoreg ? ldat : ent_alu;
    assign mem_HALT     = halt_seen;
    assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Directed bench for ex_mem_stage. Inputs change 1 ns after each rising
// edge; outputs are observed at that same point, well away from the next
// edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pipe_en;
    logic        ex_valid;
    logic        ex_dREN;
    logic        ex_dWEN;
    logic        ex_regWrite;
    logic        ex_MemtoReg;
    logic        ex_HALT;
    logic [4:0]  ex_wsel;
    logic [31:0] ex_aluResult;
    logic [31:0] ex_storeData;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        mem_stall;
    logic        mem_valid;
    logic        mem_regWrite;
    logic [4:0]  mem_wsel;
    logic [31:0] mem_wdat;
    logic        mem_HALT;
    logic [15:0] stall_cycles;

    int checks   = 0;
    int failures = 0;

    ex_mem_stage dut (
        .CLK          (CLK),
        .RST          (RST),
        .pipe_en      (pipe_en),
        .ex_valid     (ex_valid),
        .ex_dREN      (ex_dREN),
        .ex_dWEN      (ex_dWEN),
        .ex_regWrite  (ex_regWrite),
        .ex_MemtoReg  (ex_MemtoReg),
        .ex_HALT      (ex_HALT),
        .ex_wsel      (ex_wsel),
        .ex_aluResult (ex_aluResult),
        .ex_storeData (ex_storeData),
        .dhit         (dhit),
        .dmemload     (dmemload),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .dmemaddr     (dmemaddr),
        .dmemstore    (dmemstore),
        .mem_stall    (mem_stall),
        .mem_valid    (mem_valid),
        .mem_regWrite (mem_regWrite),
        .mem_wsel     (mem_wsel),
        .mem_wdat     (mem_wdat),
        .mem_HALT     (mem_HALT),
        .stall_cycles (stall_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        ex_valid     = 1'b0;
        ex_dREN      = 1'b0;
        ex_dWEN      = 1'b0;
        ex_regWrite  = 1'b0;
        ex_MemtoReg  = 1'b0;
        ex_HALT      = 1'b0;
        ex_wsel      = '0;
        ex_aluResult = '0;
        ex_storeData = '0;
    endtask

    int stall_hi;
    int wen_cnt;

    initial begin
        // ---------------- reset ----------------
        RST      = 1'b1;
        pipe_en  = 1'b0;
        dhit     = 1'b0;
        dmemload = '0;
        bubble();
        tick();
        tick();
        check("rst_valid",  32'(mem_valid),    32'd0);
        check("rst_ren",    32'(dmemREN),      32'd0);
        check("rst_wen",    32'(dmemWEN),      32'd0);
        check("rst_stall",  32'(mem_stall),    32'd0);
        check("rst_halt",   32'(mem_HALT),     32'd0);
        check("rst_wdat",   mem_wdat,          32'd0);
        check("rst_cnt",    32'(stall_cycles), 32'd0);
        RST = 1'b0;

        // ---------------- ALU op ----------------
        pipe_en      = 1'b1;
        ex_valid     = 1'b1;
        ex_regWrite  = 1'b1;
        ex_wsel      = 5'd5;
        ex_aluResult = 32'h1234;
        tick();
        check("alu_valid", 32'(mem_valid),    32'd1);
        check("alu_wdat",  mem_wdat,          32'h1234);
        check("alu_wsel",  32'(mem_wsel),     32'd5);
        check("alu_rw",    32'(mem_regWrite), 32'd1);
        check("alu_ren",   32'(dmemREN),      32'd0);
        check("alu_wen",   32'(dmemWEN),      32'd0);
        check("alu_stall", 32'(mem_stall),    32'd0);
        bubble();
        tick();
        check("bubble_valid", 32'(mem_valid), 32'd0);

        // ---------------- load, 3 wait cycles then dhit ----------------
        ex_valid     = 1'b1;
        ex_dREN      = 1'b1;
        ex_MemtoReg  = 1'b1;
        ex_regWrite  = 1'b1;
        ex_wsel      = 5'd3;
        ex_aluResult = 32'h103;
        tick();
        stall_hi = 0;
        for (int i = 0; i < 8; i++) begin
            if (!mem_stall) break;
            stall_hi++;
            check("ld_ren",   32'(dmemREN),   32'd1);
            check("ld_wen",   32'(dmemWEN),   32'd0);
            check("ld_addr",  dmemaddr,       32'h100);
            check("ld_valid", 32'(mem_valid), 32'd0);
            if (stall_hi == 4) begin
                dhit     = 1'b1;
                dmemload = 32'hCAFEF00D;
            end
            tick();
        end
        dhit = 1'b0;
        check("ld_stall_len", 32'(stall_hi),      32'd4);
        check("ld_done_valid", 32'(mem_valid),    32'd1);
        check("ld_done_wdat",  mem_wdat,          32'hCAFEF00D);
        check("ld_done_rw",    32'(mem_regWrite), 32'd1);
        check("ld_done_ren",   32'(dmemREN),      32'd0);
        check("ld_done_addr",  dmemaddr,          32'd0);
        check("ld_cnt",        32'(stall_cycles), 32'd3);

        // ---------------- store, dhit first cycle, pipe_en low ----------------
        bubble();
        ex_valid     = 1'b1;
        ex_dWEN      = 1'b1;
        ex_aluResult = 32'h200;
        ex_storeData = 32'hDEAD;
        tick();
        wen_cnt = 0;
        if (dmemWEN) wen_cnt++;
        check("st_store", dmemstore,       32'hDEAD);
        check("st_addr",  dmemaddr,        32'h200);
        check("st_stall", 32'(mem_stall),  32'd1);
        dhit    = 1'b1;
        pipe_en = 1'b0;
        tick();
        dhit = 1'b0;
        check("st_done_valid", 32'(mem_valid),    32'd1);
        check("st_done_rw",    32'(mem_regWrite), 32'd0);
        check("st_done_store", dmemstore,         32'd0);
        for (int i = 0; i < 4; i++) begin
            if (dmemWEN) wen_cnt++;
            tick();
        end
        check("st_wen_cycles", 32'(wen_cnt),      32'd1);
        check("st_cnt",        32'(stall_cycles), 32'd3);
        check("st_hold_valid", 32'(mem_valid),    32'd1);

        // ---------------- dREN & dWEN together ----------------
        pipe_en      = 1'b1;
        bubble();
        ex_valid     = 1'b1;
        ex_dREN      = 1'b1;
        ex_dWEN      = 1'b1;
        ex_regWrite  = 1'b1;
        ex_MemtoReg  = 1'b1;
        ex_wsel      = 5'd9;
        ex_aluResult = 32'h44;
        tick();
        check("rw_ren", 32'(dmemREN), 32'd0);
        check("rw_wen", 32'(dmemWEN), 32'd1);
        dhit     = 1'b1;
        dmemload = 32'hBBBB;
        tick();
        dhit = 1'b0;
        check("rw_wdat", mem_wdat,          32'h44);
        check("rw_rw",   32'(mem_regWrite), 32'd1);
        check("rw_wsel", 32'(mem_wsel),     32'd9);

        // ---------------- wsel = 0 ----------------
        bubble();
        ex_valid     = 1'b1;
        ex_regWrite  = 1'b1;
        ex_aluResult = 32'h55;
        tick();
        check("w0_valid", 32'(mem_valid),    32'd1);
        check("w0_rw",    32'(mem_regWrite), 32'd0);

        // ---------------- reset in 2nd REQ cycle ----------------
        bubble();
        ex_valid     = 1'b1;
        ex_dREN      = 1'b1;
        ex_MemtoReg  = 1'b1;
        ex_regWrite  = 1'b1;
        ex_wsel      = 5'd4;
        ex_aluResult = 32'h300;
        tick();
        check("rr_req1_ren", 32'(dmemREN), 32'd1);
        tick();
        check("rr_req2_ren", 32'(dmemREN),      32'd1);
        check("rr_req2_cnt", 32'(stall_cycles), 32'd4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bubble();
        check("rr_ren",   32'(dmemREN),      32'd0);
        check("rr_valid", 32'(mem_valid),    32'd0);
        check("rr_cnt",   32'(stall_cycles), 32'd0);
        check("rr_stall", 32'(mem_stall),    32'd0);

        // ---------------- HALT then ALU op ----------------
        ex_valid = 1'b1;
        ex_HALT  = 1'b1;
        tick();
        check("h_halt",  32'(mem_HALT),  32'd1);
        check("h_valid", 32'(mem_valid), 32'd1);
        bubble();
        ex_valid     = 1'b1;
        ex_regWrite  = 1'b1;
        ex_wsel      = 5'd7;
        ex_aluResult = 32'h77;
        tick();
        check("h2_valid", 32'(mem_valid),    32'd0);
        check("h2_rw",    32'(mem_regWrite), 32'd0);
        check("h2_wsel",  32'(mem_wsel),     32'd0);
        check("h2_halt",  32'(mem_HALT),     32'd1);
        bubble();
        tick();
        tick();
        check("h3_halt", 32'(mem_HALT), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
